// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver, LSB first, idle-high line; one byte per frame presented
// on a held parallel output with one-cycle valid and framing-error pulses.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Frame_Error
);

  localparam logic [15:0] LP_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] LP_HALF = 16'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_CLEANUP,
    S_BREAK_WAIT
  } state_t;

  state_t      r_State;
  logic        r_Rx_Meta;
  logic        r_Rx_Sync;
  logic [1:0]  r_Prime;
  logic        r_Armed;
  logic [15:0] r_Count;
  logic [2:0]  r_Index;
  logic [7:0]  r_Shift;
  logic        r_Rx_DV;
  logic [7:0]  r_Rx_Byte;
  logic        r_Frame_Error;

  logic        w_Rx_S;
  state_t      w_Next_State;
  logic [15:0] w_Next_Count;
  logic [2:0]  w_Next_Index;
  logic [7:0]  w_Next_Shift;
  logic [7:0]  w_Next_Byte;
  logic        w_Next_DV;
  logic        w_Next_FE;

  assign w_Rx_S = r_Rx_Sync;

  // The synchronizer resets high, so its output only reflects the real line
  // once r_Prime has filled; arming waits for that to avoid decoding a tail.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_Rx_Meta <= 1'b1;
      r_Rx_Sync <= 1'b1;
      r_Prime   <= '0;
      r_Armed   <= 1'b0;
    end else begin
      r_Rx_Meta <= i_Rx_Serial;
      r_Rx_Sync <= r_Rx_Meta;
      r_Prime   <= {r_Prime[0], 1'b1};
      r_Armed   <= r_Armed | (r_Prime[1] & w_Rx_S);
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_State       <= S_IDLE;
      r_Count       <= '0;
      r_Index       <= '0;
      r_Shift       <= '0;
      r_Rx_DV       <= 1'b0;
      r_Rx_Byte     <= '0;
      r_Frame_Error <= 1'b0;
    end else begin
      r_State       <= w_Next_State;
      r_Count       <= w_Next_Count;
      r_Index       <= w_Next_Index;
      r_Shift       <= w_Next_Shift;
      r_Rx_DV       <= w_Next_DV;
      r_Rx_Byte     <= w_Next_Byte;
      r_Frame_Error <= w_Next_FE;
    end
  end

  always_comb begin
    w_Next_State = r_State;
    w_Next_Count = r_Count;
    w_Next_Index = r_Index;
    w_Next_Shift = r_Shift;
    w_Next_Byte  = r_Rx_Byte;
    w_Next_DV    = 1'b0;
    w_Next_FE    = 1'b0;
    case (r_State)
      S_IDLE: begin
        w_Next_Count = '0;
        w_Next_Index = '0;
        if (r_Armed && !w_Rx_S) w_Next_State = S_START;
      end
      S_START: begin
        if (r_Count == LP_HALF) begin
          w_Next_Count = '0;
          w_Next_Index = '0;
          w_Next_State = w_Rx_S ? S_IDLE : S_DATA;
        end else begin
          w_Next_Count = r_Count + 16'd1;
        end
      end
      S_DATA: begin
        if (r_Count == LP_LAST) begin
          w_Next_Count          = '0;
          w_Next_Shift[r_Index] = w_Rx_S;
          if (r_Index == 3'd7) w_Next_State = S_STOP;
          else                 w_Next_Index = r_Index + 3'd1;
        end else begin
          w_Next_Count = r_Count + 16'd1;
        end
      end
      S_STOP: begin
        if (r_Count == LP_LAST) begin
          w_Next_Count = '0;
          if (w_Rx_S) begin
            w_Next_Byte  = r_Shift;
            w_Next_DV    = 1'b1;
            w_Next_State = S_CLEANUP;
          end else begin
            w_Next_FE    = 1'b1;
            w_Next_State = S_BREAK_WAIT;
          end
        end else begin
          w_Next_Count = r_Count + 16'd1;
        end
      end
      S_CLEANUP: begin
        w_Next_Count = '0;
        w_Next_State = S_IDLE;
      end
      S_BREAK_WAIT: begin
        w_Next_Count = '0;
        if (w_Rx_S) w_Next_State = S_IDLE;
      end
      default: begin
        w_Next_Count = '0;
        w_Next_State = S_IDLE;
      end
    endcase
  end

  assign o_Rx_DV       = r_Rx_DV;
  assign o_Rx_Byte     = r_Rx_Byte;
  assign o_Frame_Error = r_Frame_Error;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte: a CLKS_PER_BIT=4 instance for function and
// boundaries, and a default-rate instance for the latency figure.
module tb_uart_rx_byte;

  logic       clk;
  logic       rst4, rst217;
  logic       line4, line217;
  logic       dv4, dv217, fe4, fe217;
  logic [7:0] byte4, byte217;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  int         dv4_cnt = 0, fe4_cnt = 0, both4_cnt = 0;
  int         dv217_cnt = 0, fe217_cnt = 0;
  int         dv217_cyc = 0;
  logic [7:0] dv4_bytes [64];
  int         dv4_cycs  [64];
  logic [7:0] dv217_byte = '0;
  int         fall_cyc = 0;

  uart_rx_byte #(.CLKS_PER_BIT(4)) u_dut4 (
    .i_Clk(clk), .i_Reset(rst4), .i_Rx_Serial(line4),
    .o_Rx_DV(dv4), .o_Rx_Byte(byte4), .o_Frame_Error(fe4)
  );

  uart_rx_byte u_dut217 (
    .i_Clk(clk), .i_Reset(rst217), .i_Rx_Serial(line217),
    .o_Rx_DV(dv217), .o_Rx_Byte(byte217), .o_Frame_Error(fe217)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dv4) begin
      if (dv4_cnt < 64) begin
        dv4_bytes[dv4_cnt] = byte4;
        dv4_cycs[dv4_cnt]  = cyc;
      end
      dv4_cnt++;
    end
    if (fe4) fe4_cnt++;
    if (dv4 && fe4) both4_cnt++;
    if (dv217) begin
      dv217_cnt++;
      dv217_cyc  = cyc;
      dv217_byte = byte217;
    end
    if (fe217) fe217_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input int sel, input logic v);
    if (sel == 4) line4 = v;
    else          line217 = v;
  endtask

  task automatic send_frame(input int sel, input logic [7:0] b, input logic stopb, input int cpb);
    drive(sel, 1'b0);
    fall_cyc = cyc;
    wait_cycles(cpb);
    for (int i = 0; i < 8; i++) begin
      drive(sel, b[i]);
      wait_cycles(cpb);
    end
    drive(sel, stopb);
    wait_cycles(cpb);
    drive(sel, 1'b1);
  endtask

  int dv0, fe0, lat;
  logic [9:0] c3_bits;

  initial begin
    rst4 = 1'b1; rst217 = 1'b1; line4 = 1'b1; line217 = 1'b1;
    wait_cycles(3);
    check("rst_dv4",   32'(dv4),    32'h0);
    check("rst_fe4",   32'(fe4),    32'h0);
    check("rst_byte4", 32'(byte4),  32'h00);
    check("rst_dv217", 32'(dv217),  32'h0);
    check("rst_byte217", 32'(byte217), 32'h00);
    rst4 = 1'b0; rst217 = 1'b0;
    wait_cycles(6);

    // Clean frame
    dv0 = dv4_cnt; fe0 = fe4_cnt;
    send_frame(4, 8'h37, 1'b1, 4);
    wait_cycles(10);
    check("clean_dv_count", 32'(dv4_cnt - dv0), 32'd1);
    check("clean_byte_at_dv", 32'(dv4_bytes[dv0]), 32'h37);
    check("clean_fe_count", 32'(fe4_cnt - fe0), 32'd0);
    wait_cycles(20);
    check("clean_byte_held", 32'(byte4), 32'h37);

    // Back-to-back frames
    dv0 = dv4_cnt;
    send_frame(4, 8'hA5, 1'b1, 4);
    send_frame(4, 8'h5A, 1'b1, 4);
    wait_cycles(10);
    check("b2b_dv_count", 32'(dv4_cnt - dv0), 32'd2);
    check("b2b_byte0", 32'(dv4_bytes[dv0]), 32'hA5);
    check("b2b_byte1", 32'(dv4_bytes[dv0+1]), 32'h5A);
    check("b2b_spacing", 32'(dv4_cycs[dv0+1] - dv4_cycs[dv0]), 32'd40);

    // Start glitch
    dv0 = dv4_cnt; fe0 = fe4_cnt;
    line4 = 1'b0;
    wait_cycles(1);
    line4 = 1'b1;
    wait_cycles(20);
    check("glitch_dv_count", 32'(dv4_cnt - dv0), 32'd0);
    check("glitch_fe_count", 32'(fe4_cnt - fe0), 32'd0);
    send_frame(4, 8'h01, 1'b1, 4);
    wait_cycles(10);
    check("glitch_next_dv", 32'(dv4_cnt - dv0), 32'd1);
    check("glitch_next_byte", 32'(byte4), 32'h01);

    // Framing error followed by a held-low break
    send_frame(4, 8'h37, 1'b1, 4);
    wait_cycles(6);
    dv0 = dv4_cnt; fe0 = fe4_cnt;
    send_frame(4, 8'hFF, 1'b0, 4);
    line4 = 1'b0;
    wait_cycles(40);
    line4 = 1'b1;
    wait_cycles(10);
    check("ferr_fe_count", 32'(fe4_cnt - fe0), 32'd1);
    check("ferr_dv_count", 32'(dv4_cnt - dv0), 32'd0);
    check("ferr_byte_kept", 32'(byte4), 32'h37);
    send_frame(4, 8'h42, 1'b1, 4);
    wait_cycles(10);
    check("ferr_next_dv", 32'(dv4_cnt - dv0), 32'd1);
    check("ferr_next_byte", 32'(byte4), 32'h42);

    // Reset during data bit 3 of 0xC3 while the line is low
    dv0 = dv4_cnt; fe0 = fe4_cnt;
    c3_bits = {1'b1, 8'hC3, 1'b0};
    for (int i = 0; i < 10; i++) begin
      line4 = c3_bits[i];
      if (i == 4) begin
        wait_cycles(2);
        rst4 = 1'b1;
        #1;
        check("midrst_dv",   32'(dv4),   32'h0);
        check("midrst_fe",   32'(fe4),   32'h0);
        check("midrst_byte", 32'(byte4), 32'h00);
        wait_cycles(2);
        rst4 = 1'b0;
      end else begin
        wait_cycles(4);
      end
    end
    line4 = 1'b1;
    wait_cycles(20);
    check("midrst_tail_dv", 32'(dv4_cnt - dv0), 32'd0);
    check("midrst_tail_fe", 32'(fe4_cnt - fe0), 32'd0);
    send_frame(4, 8'h99, 1'b1, 4);
    wait_cycles(10);
    check("midrst_next_dv", 32'(dv4_cnt - dv0), 32'd1);
    check("midrst_next_byte", 32'(byte4), 32'h99);
    check("dv_fe_exclusive", 32'(both4_cnt), 32'd0);

    // Default rate: latency = 108 + 9*217 + 4 = 2065 cycles, +/-1
    dv0 = dv217_cnt;
    send_frame(217, 8'h55, 1'b1, 217);
    wait_cycles(50);
    lat = dv217_cyc - fall_cyc;
    check("p217_dv_count", 32'(dv217_cnt - dv0), 32'd1);
    check("p217_latency_in_window", 32'((lat >= 2064) && (lat <= 2066)), 32'd1);
    check("p217_byte", 32'(dv217_byte), 32'h55);
    check("p217_fe_count", 32'(fe217_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
